match_controller: RTL and testbench
===================================

Name: match_controller

Overview:
- Sequences the tug-of-war playfield (nine light FSMs plus the two input conditioners) through a best-of match against the cyberplayer.
- Owns the playfield reset and pull gating, counts round wins for both sides, and configures the cyberplayer comparator threshold.
- The threshold ramps the CPU difficulty each time the human wins a round.
- Sits between the userInput/meta front end and the light chain, replacing resetHandler and the per-side winCounter reset path.

Parameters:
- WINS_TO_MATCH, 3: round wins that end the match (1..7).
- COUNT_CYCLES, 4: countdown length in clk cycles before play opens (>=1).
- HOLD_CYCLES, 4: cycles the finished field is held in reset after a round win (>=1).
- DIFF_STEP, 32: threshold increment applied per human round win.
- MAX_DIFF, 480: saturation ceiling for cpuThreshold (<=511).

Ports:
- clk  input  1  divided game clock (clk[whichClock])
- reset  input  1  asynchronous active-high reset
- start  input  1  begin match; level, sampled each cycle
- Lpull  input  1  conditioned CPU pull pulse
- Rpull  input  1  conditioned human pull pulse
- leftEdge  input  1  leftmost field light on (LEDR[9])
- rightEdge  input  1  rightmost field light on (LEDR[1])
- baseDifficulty  input  9  initial CPU threshold (SW[8:0])
- fieldReset  output  1  reset to all light FSMs
- pullEnable  output  1  gates Lpull/Rpull into the light chain
- cpuThreshold  output  9  A-operand for the cyberplayer comparator
- Lwins  output  3  CPU round wins
- Rwins  output  3  human round wins
- matchOver  output  1  match decided
- winner  output  1  1 = human (right), 0 = CPU; valid only while matchOver=1

Behaviour:
- All outputs are registered. Reset forces state IDLE immediately and sets: fieldReset=1, pullEnable=0, cpuThreshold=0, Lwins=0, Rwins=0, matchOver=0, winner=0, timer=0.
- States are IDLE, COUNTDOWN, PLAY, ROUND_OVER, MATCH_OVER. fieldReset=1 and pullEnable=0 in every state except PLAY, where fieldReset=0 and pullEnable=1.
- IDLE: start=1 -> COUNTDOWN. On that transition: Lwins=Rwins=0, cpuThreshold=baseDifficulty, timer=COUNT_CYCLES-1.
- COUNTDOWN: timer decrements each cycle. timer==0 -> PLAY.
- PLAY:
  - leftWin = leftEdge & Lpull.
  - rightWin = rightEdge & Rpull.
  - If exactly one is set, increment that side's count (3-bit, never exceeds WINS_TO_MATCH).
  - If the new count equals WINS_TO_MATCH -> MATCH_OVER: matchOver=1, winner=rightWin.
  - Otherwise -> ROUND_OVER with timer=HOLD_CYCLES-1.
  - Both set (illegal field state) or neither set: stay in PLAY, no count change.
- Difficulty ramp: on rightWin in PLAY, cpuThreshold = min(cpuThreshold + DIFF_STEP, MAX_DIFF). Compute the sum at 10 bits, then saturate. A left win leaves cpuThreshold unchanged.
- ROUND_OVER: timer decrements. timer==0 -> COUNTDOWN with timer=COUNT_CYCLES-1. Counts are held.
- MATCH_OVER: matchOver, winner and counts are held. start=1 -> COUNTDOWN with the same clearing and reload as the IDLE->COUNTDOWN transition; matchOver is cleared.
- start is ignored in COUNTDOWN, PLAY and ROUND_OVER.
- Latency: a win sampled at edge N updates counts and state at edge N; fieldReset is seen high from edge N onward. The first PLAY cycle (pullEnable=1) begins exactly COUNT_CYCLES edges after the edge that left IDLE, ROUND_OVER or MATCH_OVER.
- Asserting reset mid-round aborts the round asynchronously. Nothing persists across reset.

Decomposition:
- Shared package tow_pkg holds:
  - typedef enum logic [2:0] match_state_t {IDLE, COUNTDOWN, PLAY, ROUND_OVER, MATCH_OVER};
  - localparams for threshold width (9) and win-counter width (3).
  - the WINNER_HUMAN/WINNER_CPU encodings.
- One natural sub-module, phase_timer: a loadable down-counter with a done flag, width $clog2(max(COUNT_CYCLES,HOLD_CYCLES)), same clk/reset. It is used for both the countdown and the hold phase.

Test Plan:
- Reset asserted mid-PLAY -> outputs immediately go to fieldReset=1, pullEnable=0, cpuThreshold=0, Lwins=Rwins=0, state IDLE, before the next clk edge.
- baseDifficulty=100, start pulse at edge 0 -> cpuThreshold=100 at edge 0; pullEnable=1 from edge 4 onward; fieldReset=0 from edge 4.
- In PLAY, rightEdge=1 with one Rpull pulse -> Rwins=1, cpuThreshold=132, state ROUND_OVER for 4 cycles, then COUNTDOWN for 4 cycles, then PLAY.
- baseDifficulty=470, one human round win -> cpuThreshold saturates at 480 (not 502); a second human win keeps it at 480.
- CPU wins 3 rounds (leftEdge&Lpull) -> Lwins=3, matchOver=1, winner=0. Further Lpull/Rpull pulses cause no change; start restarts with Lwins=0 and cpuThreshold reloaded.
- Illegal leftEdge=rightEdge=1 with Lpull=Rpull=1 in PLAY -> no count change, state stays PLAY. start held high during PLAY -> ignored.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war match controller.
// Holds the match FSM state encoding, datapath widths and the winner encodings.
package tow_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    ROUND_OVER,
    MATCH_OVER
  } match_state_t;

  localparam int THR_W = 9;  // cyberplayer threshold width
  localparam int WIN_W = 3;  // round-win counter width

  localparam logic WINNER_HUMAN = 1'b1;
  localparam logic WINNER_CPU   = 1'b0;

endpackage

// File: rtl/match_controller_phase_timer.sv
// phase_timer: loadable down-counter with a done flag.
// Used for both the pre-play countdown and the post-round hold.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset (count -> 0)
//   i_load       : load i_load_val this cycle (has priority over i_en)
//   i_load_val   : value to load
//   i_en         : decrement by one when the count is non-zero
//   o_done       : count is zero (decoded from the register)
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/match_controller.sv
// match_controller: sequences the tug-of-war playfield through a best-of
// match against the cyberplayer. Owns playfield reset and pull gating,
// counts round wins per side and ramps the CPU comparator threshold every
// time the human wins a round.
// Ports:
//   clk, reset         : divided game clock, asynchronous active-high reset
//   start              : level; begins a match from IDLE or MATCH_OVER
//   Lpull, Rpull       : conditioned CPU / human pull pulses
//   leftEdge,rightEdge : outermost field lights
//   baseDifficulty     : threshold loaded at match start
//   fieldReset         : reset to the light FSMs (low only in PLAY)
//   pullEnable         : gates pulls into the light chain (high only in PLAY)
//   cpuThreshold       : cyberplayer comparator A-operand
//   Lwins, Rwins       : CPU / human round wins
//   matchOver, winner  : match decided; winner 1 = human, 0 = CPU
//   dbg_state          : current FSM state, for observation
module match_controller
  import tow_pkg::*;
#(
  parameter int WINS_TO_MATCH = 3,
  parameter int COUNT_CYCLES  = 4,
  parameter int HOLD_CYCLES   = 4,
  parameter int DIFF_STEP     = 32,
  parameter int MAX_DIFF      = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Lpull,
  input  logic             Rpull,
  input  logic             leftEdge,
  input  logic             rightEdge,
  input  logic [THR_W-1:0] baseDifficulty,
  output logic             fieldReset,
  output logic             pullEnable,
  output logic [THR_W-1:0] cpuThreshold,
  output logic [WIN_W-1:0] Lwins,
  output logic [WIN_W-1:0] Rwins,
  output logic             matchOver,
  output logic             winner,
  output match_state_t     dbg_state
);

  localparam int TMAX = (COUNT_CYCLES > HOLD_CYCLES) ? COUNT_CYCLES : HOLD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    COUNT_LOAD = TW'(COUNT_CYCLES - 1);
  localparam logic [TW-1:0]    HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [WIN_W-1:0] WINS_MAX   = WIN_W'(WINS_TO_MATCH);
  localparam logic [THR_W:0]   STEP_EXT   = (THR_W + 1)'(DIFF_STEP);
  localparam logic [THR_W:0]   MAX_EXT    = (THR_W + 1)'(MAX_DIFF);

  match_state_t     r_state;
  logic             r_field_reset;
  logic             r_pull_enable;
  logic [THR_W-1:0] r_threshold;
  logic [WIN_W-1:0] r_lwins;
  logic [WIN_W-1:0] r_rwins;
  logic             r_match_over;
  logic             r_winner;

  logic             w_left_win;
  logic             w_right_win;
  logic             w_one_win;
  logic             w_start_match;
  logic [WIN_W-1:0] w_lwins_inc;
  logic [WIN_W-1:0] w_rwins_inc;
  logic             w_match_won;
  logic [THR_W:0]   w_thr_sum;
  logic [THR_W-1:0] w_thr_ramp;
  logic             w_tmr_load;
  logic [TW-1:0]    w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_done;

  assign w_left_win    = leftEdge & Lpull;
  assign w_right_win   = rightEdge & Rpull;
  // Both edges lit at once is an illegal field state: ignore it like no win.
  assign w_one_win     = w_left_win ^ w_right_win;
  assign w_start_match = start && ((r_state == IDLE) || (r_state == MATCH_OVER));
  assign w_lwins_inc   = r_lwins + 1'b1;
  assign w_rwins_inc   = r_rwins + 1'b1;
  assign w_match_won   = w_right_win ? (w_rwins_inc == WINS_MAX) : (w_lwins_inc == WINS_MAX);

  // Sum one bit wider so the carry out of 511 is not lost before saturating.
  assign w_thr_sum  = {1'b0, r_threshold} + STEP_EXT;
  assign w_thr_ramp = (w_thr_sum > MAX_EXT) ? MAX_EXT[THR_W-1:0] : w_thr_sum[THR_W-1:0];

  // Timer load/enable decode: reload for the countdown on match start and at
  // the end of a hold; reload for the hold on a non-final round win.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = COUNT_LOAD;
    w_tmr_en   = (r_state == COUNTDOWN) || (r_state == ROUND_OVER);
    if (w_start_match) begin
      w_tmr_load = 1'b1;
    end else if ((r_state == PLAY) && w_one_win && !w_match_won) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = HOLD_LOAD;
    end else if ((r_state == ROUND_OVER) && w_tmr_done) begin
      w_tmr_load = 1'b1;
    end
  end

  phase_timer #(
    .W(TW)
  ) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_en      (w_tmr_en),
    .o_done    (w_tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_field_reset <= 1'b1;
      r_pull_enable <= 1'b0;
      r_threshold   <= '0;
      r_lwins       <= '0;
      r_rwins       <= '0;
      r_match_over  <= 1'b0;
      r_winner      <= WINNER_CPU;
    end else begin
      case (r_state)
        IDLE, MATCH_OVER: begin
          if (start) begin
            r_state      <= COUNTDOWN;
            r_lwins      <= '0;
            r_rwins      <= '0;
            r_threshold  <= baseDifficulty;
            r_match_over <= 1'b0;
          end
        end
        COUNTDOWN: begin
          if (w_tmr_done) begin
            r_state       <= PLAY;
            r_field_reset <= 1'b0;
            r_pull_enable <= 1'b1;
          end
        end
        PLAY: begin
          if (w_one_win) begin
            r_field_reset <= 1'b1;
            r_pull_enable <= 1'b0;
            if (w_right_win) begin
              r_rwins     <= w_rwins_inc;
              r_threshold <= w_thr_ramp;
            end else begin
              r_lwins <= w_lwins_inc;
            end
            if (w_match_won) begin
              r_state      <= MATCH_OVER;
              r_match_over <= 1'b1;
              r_winner     <= w_right_win ? WINNER_HUMAN : WINNER_CPU;
            end else begin
              r_state <= ROUND_OVER;
            end
          end
        end
        ROUND_OVER: begin
          if (w_tmr_done) begin
            r_state <= COUNTDOWN;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_field_reset <= 1'b1;
          r_pull_enable <= 1'b0;
        end
      endcase
    end
  end

  assign fieldReset   = r_field_reset;
  assign pullEnable   = r_pull_enable;
  assign cpuThreshold = r_threshold;
  assign Lwins        = r_lwins;
  assign Rwins        = r_rwins;
  assign matchOver    = r_match_over;
  assign winner       = r_winner;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios followed by
// randomized play, all compared against a timeline-based reference model.
module tb_match_controller;
  import tow_pkg::*;

  localparam int WINS = 3;
  localparam int CC   = 4;
  localparam int HC   = 4;
  localparam int STEP = 32;
  localparam int MAXD = 480;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic       start;
  logic       Lpull;
  logic       Rpull;
  logic       leftEdge;
  logic       rightEdge;
  logic [8:0] baseDifficulty;
  logic       fieldReset;
  logic       pullEnable;
  logic [8:0] cpuThreshold;
  logic [2:0] Lwins;
  logic [2:0] Rwins;
  logic       matchOver;
  logic       winner;
  match_state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  match_controller #(
    .WINS_TO_MATCH(WINS),
    .COUNT_CYCLES (CC),
    .HOLD_CYCLES  (HC),
    .DIFF_STEP    (STEP),
    .MAX_DIFF     (MAXD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .Lpull         (Lpull),
    .Rpull         (Rpull),
    .leftEdge      (leftEdge),
    .rightEdge     (rightEdge),
    .baseDifficulty(baseDifficulty),
    .fieldReset    (fieldReset),
    .pullEnable    (pullEnable),
    .cpuThreshold  (cpuThreshold),
    .Lwins         (Lwins),
    .Rwins         (Rwins),
    .matchOver     (matchOver),
    .winner        (winner),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The match is modelled as a timeline: m_wait counts edges until play opens.
  // Entering a match opens play after CC edges; a non-final round win opens
  // it again after HC+CC edges, the first HC of which are the hold.
  bit m_idle;
  bit m_over;
  int m_wait;
  int m_thr;
  int m_lw;
  int m_rw;
  bit m_winner;

  function automatic bit m_playing();
    return !m_idle && !m_over && (m_wait == 0);
  endfunction

  task automatic model_reset();
    m_idle = 1; m_over = 0; m_wait = 0; m_thr = 0; m_lw = 0; m_rw = 0; m_winner = 0;
  endtask

  task automatic model_step();
    bit lw_hit;
    bit rw_hit;
    lw_hit = leftEdge && Lpull;
    rw_hit = rightEdge && Rpull;
    if (m_idle || m_over) begin
      if (start) begin
        m_idle = 0; m_over = 0; m_lw = 0; m_rw = 0;
        m_thr = int'(baseDifficulty); m_wait = CC;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (lw_hit != rw_hit) begin
      if (rw_hit) begin
        m_rw++;
        m_thr = (m_thr + STEP > MAXD) ? MAXD : m_thr + STEP;
      end else begin
        m_lw++;
      end
      if (m_lw == WINS || m_rw == WINS) begin
        m_over = 1; m_winner = rw_hit;
      end else begin
        m_wait = HC + CC;
      end
    end
  endtask

  function automatic match_state_t m_state();
    if (m_idle)      return IDLE;
    if (m_over)      return MATCH_OVER;
    if (m_wait > CC) return ROUND_OVER;
    if (m_wait > 0)  return COUNTDOWN;
    return PLAY;
  endfunction

  task automatic check_all();
    chk("fieldReset", 32'(fieldReset), 32'(!m_playing()));
    chk("pullEnable", 32'(pullEnable), 32'(m_playing()));
    chk("cpuThreshold", 32'(cpuThreshold), 32'(m_thr));
    chk("Lwins", 32'(Lwins), 32'(m_lw));
    chk("Rwins", 32'(Rwins), 32'(m_rw));
    chk("matchOver", 32'(matchOver), 32'(m_over));
    if (m_over) chk("winner", 32'(winner), 32'(m_winner));
    chk("state", 32'(dbg_state), 32'(m_state()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_play();
    Lpull = 0; Rpull = 0; leftEdge = 0; rightEdge = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; start = 0; baseDifficulty = '0;
    clear_play();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 0;

    // Match start and countdown latency.
    baseDifficulty = 9'd100;
    start = 1;
    tick();
    start = 0;
    chk("thr_base", 32'(cpuThreshold), 32'd100);
    repeat (CC - 1) tick();
    chk("pull_closed", 32'(pullEnable), 32'd0);
    tick();
    chk("pull_open", 32'(pullEnable), 32'd1);
    chk("field_run", 32'(fieldReset), 32'd0);

    // Human round win, then hold and countdown back to play.
    rightEdge = 1; Rpull = 1;
    tick();
    clear_play();
    chk("rwin_count", 32'(Rwins), 32'd1);
    chk("rwin_thr", 32'(cpuThreshold), 32'd132);
    chk("hold_state", 32'(dbg_state), 32'(ROUND_OVER));
    repeat (HC - 1) tick();
    chk("hold_end", 32'(dbg_state), 32'(ROUND_OVER));
    tick();
    chk("recount", 32'(dbg_state), 32'(COUNTDOWN));
    repeat (CC) tick();
    chk("replay", 32'(dbg_state), 32'(PLAY));

    // Illegal double-edge win and start held during play.
    leftEdge = 1; rightEdge = 1; Lpull = 1; Rpull = 1; start = 1;
    repeat (3) tick();
    clear_play(); start = 0;
    chk("illegal_l", 32'(Lwins), 32'd0);
    chk("illegal_r", 32'(Rwins), 32'd1);
    chk("illegal_st", 32'(dbg_state), 32'(PLAY));

    // CPU takes the match.
    for (int k = 0; k < WINS; k++) begin
      leftEdge = 1; Lpull = 1;
      tick();
      clear_play();
      if (k < WINS - 1) repeat (HC + CC) tick();
    end
    chk("cpu_lwins", 32'(Lwins), 32'd3);
    chk("cpu_over", 32'(matchOver), 32'd1);
    chk("cpu_winner", 32'(winner), 32'd0);
    leftEdge = 1; rightEdge = 1;
    for (int k = 0; k < 4; k++) begin
      Lpull = k[0]; Rpull = !k[0];
      tick();
    end
    clear_play();
    chk("over_hold", 32'(Lwins), 32'd3);

    // Restart from MATCH_OVER with a high base: saturation.
    baseDifficulty = 9'd470;
    start = 1;
    tick();
    start = 0;
    chk("restart_l", 32'(Lwins), 32'd0);
    chk("restart_thr", 32'(cpuThreshold), 32'd470);
    repeat (CC) tick();
    rightEdge = 1; Rpull = 1;
    tick();
    clear_play();
    chk("sat_1", 32'(cpuThreshold), 32'd480);
    repeat (HC + CC) tick();
    rightEdge = 1; Rpull = 1;
    tick();
    clear_play();
    chk("sat_2", 32'(cpuThreshold), 32'd480);

    // Asynchronous reset in the middle of play.
    repeat (HC + CC) tick();
    chk("pre_reset", 32'(dbg_state), 32'(PLAY));
    #2;
    reset = 1;
    #1;
    model_reset();
    check_all();
    chk("async_rst", 32'(dbg_state), 32'(IDLE));
    #1;
    reset = 0;

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      start          = ($urandom_range(0, 19) == 0);
      baseDifficulty = 9'($urandom_range(0, 511));
      leftEdge       = ($urandom_range(0, 2) == 0);
      rightEdge      = ($urandom_range(0, 2) == 0);
      Lpull          = ($urandom_range(0, 1) == 0);
      Rpull          = ($urandom_range(0, 1) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
